// File: rtl/fabint_pkg.sv
// Shared constants and types for the fabric interrupt controller.
package fabint_pkg;

  // Widest source vector the register map can expose.
  localparam int MAX_SRC = 32;

  // Byte offsets of the register map; only PADDR[4:2] is decoded.
  localparam logic [4:0] OFS_STATUS = 5'h00;
  localparam logic [4:0] OFS_PEND   = 5'h04;
  localparam logic [4:0] OFS_EN     = 5'h08;
  localparam logic [4:0] OFS_MODE   = 5'h0C;
  localparam logic [4:0] OFS_POL    = 5'h10;
  localparam logic [4:0] OFS_VECTOR = 5'h14;

  // APB slave handshake states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } apb_state_t;

endpackage

// File: rtl/fabint_src_cell.sv
// One interrupt source: two-flop synchronizer, polarity, edge detect, pending flop.
module fabint_src_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_irq,
  input  logic i_pol,
  input  logic i_mode,
  input  logic i_clr,
  output logic o_pend
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic r_pend;
  logic w_s;
  logic w_rise;

  // Polarity is applied after synchronization so a POL change acts next cycle.
  assign w_s    = r_sync2 ^ i_pol;
  assign w_rise = w_s & ~r_hist;
  assign o_pend = r_pend;

  // Synchronize, track history, and capture pending (new edge beats a clear).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
      r_hist  <= w_s;
      if (i_mode) begin
        r_pend <= w_rise | (r_pend & ~i_clr);
      end else begin
        r_pend <= w_s;
      end
    end
  end

endmodule

// File: rtl/fabint_controller.sv
// APB3 slave aggregating fabric interrupt sources into the MSS FABINT line.
module fabint_controller
  import fabint_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_SRC-1:0]  IRQ_SRC,
  output logic                FABINT
);

  apb_state_t            r_state;
  apb_state_t            w_state_next;
  logic [NUM_SRC-1:0]    r_en;
  logic [NUM_SRC-1:0]    r_mode;
  logic [NUM_SRC-1:0]    r_pol;
  logic                  r_fabint;
  logic [NUM_SRC-1:0]    w_pend;
  logic [NUM_SRC-1:0]    w_status;
  logic [NUM_SRC-1:0]    w_pend_clr;
  logic [4:0]            w_ofs;
  logic                  w_bad_ofs;
  logic                  w_ro;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_commit;
  logic [MAX_SRC-1:0]    w_vector;
  logic [MAX_SRC-1:0]    w_rdata;
  logic                  w_unused_bits;

  // Address bits outside [4:2] and write data above NUM_SRC are ignored.
  assign w_unused_bits = ^{PADDR, PWDATA};

  assign w_ofs     = {PADDR[4:2], 2'b00};
  assign w_bad_ofs = (w_ofs == 5'h18) || (w_ofs == 5'h1C);
  assign w_ro      = (w_ofs == OFS_STATUS) || (w_ofs == OFS_VECTOR);
  assign w_err     = w_bad_ofs || (PWRITE && w_ro);
  assign w_status  = w_pend & r_en;

  // W1C strobe reaches the cells only on a committed, error-free PEND write.
  assign w_pend_clr = (w_commit && (w_ofs == OFS_PEND)) ? PWDATA[NUM_SRC-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fabint_src_cell u_cell (
        .i_clk   (PCLK),
        .i_rst_n (PRESETN),
        .i_irq   (IRQ_SRC[gi]),
        .i_pol   (r_pol[gi]),
        .i_mode  (r_mode[gi]),
        .i_clr   (w_pend_clr[gi]),
        .o_pend  (w_pend[gi])
      );
    end
  endgenerate

  // APB state register.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake; DONE holds until the master ends the access.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && PENABLE) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!PSEL) begin
          w_state_next = ST_IDLE;
        end else begin
          w_ready      = 1'b1;
          w_commit     = PWRITE && !w_err;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!PSEL || !PENABLE) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Writable configuration registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_en   <= '0;
      r_mode <= '0;
      r_pol  <= '0;
    end else if (w_commit) begin
      case (w_ofs)
        OFS_EN:   r_en   <= PWDATA[NUM_SRC-1:0];
        OFS_MODE: r_mode <= PWDATA[NUM_SRC-1:0];
        OFS_POL:  r_pol  <= PWDATA[NUM_SRC-1:0];
        default:  ;
      endcase
    end
  end

  // Lowest-numbered active source wins; scan downward so the last hit is lowest.
  always_comb begin
    w_vector = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_status[i]) begin
        w_vector[31]  = 1'b1;
        w_vector[4:0] = 5'(i);
      end
    end
  end

  // Read mux; data is only presented while PREADY is high on a good read.
  always_comb begin
    w_rdata = '0;
    if (w_ready && !w_err && !PWRITE) begin
      case (w_ofs)
        OFS_STATUS: w_rdata[NUM_SRC-1:0] = w_status;
        OFS_PEND:   w_rdata[NUM_SRC-1:0] = w_pend;
        OFS_EN:     w_rdata[NUM_SRC-1:0] = r_en;
        OFS_MODE:   w_rdata[NUM_SRC-1:0] = r_mode;
        OFS_POL:    w_rdata[NUM_SRC-1:0] = r_pol;
        OFS_VECTOR: w_rdata              = w_vector;
        default:    w_rdata              = '0;
      endcase
    end
  end

  // Registered aggregate interrupt.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_fabint <= 1'b0;
    end else begin
      r_fabint <= |w_status;
    end
  end

  assign PRDATA  = w_rdata;
  assign PREADY  = w_ready;
  assign PSLVERR = w_ready && w_err;
  assign FABINT  = r_fabint;

endmodule

// File: tb/tb_fabint_controller.sv
// Scoreboard bench for fabint_controller: stimulus queues expectations, monitor checks.
module tb_fabint_controller;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'h00;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  IRQ_SRC = 8'h00;
  logic        FABINT;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  fabint_controller #(.NUM_SRC(8), .ADDR_W(8)) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .IRQ_SRC (IRQ_SRC),
    .FABINT  (FABINT)
  );

  always #5 PCLK = ~PCLK;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  // Monitor: every completed transfer pops one expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETN && PREADY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (!e.wr) check($sformatf("prdata@%02h", e.addr), PRDATA, e.rdata);
        check($sformatf("pslverr@%02h", e.addr), {31'd0, PSLVERR}, {31'd0, e.err});
        $display("txn %s addr=%02h prdata=%08h pslverr=%0d", e.wr ? "WR" : "RD", e.addr, PRDATA, PSLVERR);
      end
    end
  end

  // One APB transfer; optional IRQ pulse aligned so its capture edge is the commit edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input logic [7:0] pulse);
    exp_t e;
    int   waits;
    logic got;
    e.addr = addr; e.wr = wr; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    IRQ_SRC = IRQ_SRC | pulse;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    IRQ_SRC = IRQ_SRC & ~pulse;
    waits = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge PCLK);
      if (PREADY) got = 1'b1;
      else waits++;
    end
    check($sformatf("ready_seen@%02h", addr), {31'd0, got}, 32'd1);
    check($sformatf("wait_states@%02h", addr), waits, 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    apb(1'b0, addr, 32'h0, exp_rd, exp_err, 8'h00);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic exp_err);
    apb(1'b1, addr, data, 32'h0, exp_err, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", {31'd0, PREADY}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("rst_fabint", {31'd0, FABINT}, 32'd0);
    PRESETN = 1'b1;

    // Readback of the whole map after reset
    for (int a = 0; a < 6; a++) rd(8'(a * 4), 32'h0, 1'b0);
    check("fabint_idle", {31'd0, FABINT}, 32'd0);

    // Edge interrupt on source 2, FABINT exactly 4 clocks later
    wr(8'h08, 32'h05, 1'b0);
    wr(8'h0C, 32'hFF, 1'b0);
    rd(8'h08, 32'h05, 1'b0);
    rd(8'h0C, 32'hFF, 1'b0);
    @(posedge PCLK); #1;
    IRQ_SRC[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge PCLK); #1;
      if (k == 1) IRQ_SRC[2] = 1'b0;
      check($sformatf("edge_fabint_k%0d", k), {31'd0, FABINT}, (k == 4) ? 32'd1 : 32'd0);
    end
    rd(8'h14, 32'h8000_0002, 1'b0);
    rd(8'h00, 32'h04, 1'b0);
    rd(8'h04, 32'h04, 1'b0);
    wr(8'h04, 32'h04, 1'b0);
    @(posedge PCLK); #1;
    check("w1c_fabint", {31'd0, FABINT}, 32'd0);
    rd(8'h04, 32'h00, 1'b0);

    // Priority: sources 5 and 1 pending, lowest wins
    wr(8'h08, 32'hFF, 1'b0);
    @(posedge PCLK); #1;
    IRQ_SRC = 8'h22;
    @(posedge PCLK); #1;
    IRQ_SRC = 8'h00;
    repeat (4) @(posedge PCLK);
    rd(8'h14, 32'h8000_0001, 1'b0);
    rd(8'h04, 32'h22, 1'b0);

    // Set wins over W1C in the same cycle, then a plain W1C clears
    apb(1'b1, 8'h04, 32'h02, 32'h0, 1'b0, 8'h02);
    rd(8'h04, 32'h22, 1'b0);
    wr(8'h04, 32'h02, 1'b0);
    rd(8'h04, 32'h20, 1'b0);
    rd(8'h14, 32'h8000_0005, 1'b0);

    // Level mode with active-low source 3
    wr(8'h0C, 32'h00, 1'b0);
    wr(8'h08, 32'h08, 1'b0);
    wr(8'h10, 32'h08, 1'b0);
    repeat (3) @(posedge PCLK);
    rd(8'h04, 32'h08, 1'b0);
    check("level_fabint", {31'd0, FABINT}, 32'd1);
    rd(8'h14, 32'h8000_0003, 1'b0);
    wr(8'h04, 32'h08, 1'b0);
    rd(8'h04, 32'h08, 1'b0);

    // Error responses change nothing
    rd(8'h18, 32'h0, 1'b1);
    rd(8'h1C, 32'h0, 1'b1);
    wr(8'h00, 32'hFFFF_FFFF, 1'b1);
    wr(8'h14, 32'hFFFF_FFFF, 1'b1);
    wr(8'h18, 32'hFFFF_FFFF, 1'b1);
    rd(8'h00, 32'h08, 1'b0);
    rd(8'h08, 32'h08, 1'b0);
    rd(8'h04, 32'h08, 1'b0);
    rd(8'h10, 32'h08, 1'b0);

    // Deasserting source 3 drops PEND after 3 clocks, FABINT after 4
    @(posedge PCLK); #1;
    IRQ_SRC[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge PCLK); #1;
      check($sformatf("level_off_fabint_k%0d", k), {31'd0, FABINT}, (k == 4) ? 32'd0 : 32'd1);
    end
    rd(8'h04, 32'h00, 1'b0);

    // Asynchronous reset during the WAIT cycle of an EN write
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    IRQ_SRC = 8'h00;
    #1;
    check("rst_mid_pready", {31'd0, PREADY}, 32'd0);
    check("rst_mid_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETN = 1'b1;
    rd(8'h08, 32'h00, 1'b0);
    wr(8'h08, 32'h5A, 1'b0);
    rd(8'h08, 32'h5A, 1'b0);

    // PSEL dropped in WAIT aborts without committing
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h33;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check("abort_pready", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PWRITE = 1'b0;
    rd(8'h08, 32'h5A, 1'b0);

    repeat (2) @(posedge PCLK);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
